// File: rtl/imem_loader.sv
// UART boot loader: receives an A5-framed, length-prefixed, XOR-checksummed byte
// stream and writes it as little-endian 32-bit words into instruction memory.
module imem_loader #(
  parameter int CLK_FREQ_HZ = 40000000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UART_RX,
  output logic              IMEM_W_En,
  output logic [ADDR_W-1:0] IMEM_W_Addr,
  output logic [31:0]       IMEM_W_Data,
  output logic              Core_Hold,
  output logic              Load_Done,
  output logic              Load_Err
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD;
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV + 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHK    = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  logic [1:0]        rx_state_q, rx_state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_vld_q, byte_vld_d;
  logic              frame_err_q, frame_err_d;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       word_q, word_d;
  logic [7:0]        chk_q, chk_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [31:0]       w_data_q, w_data_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [15:0]       count_w;

  assign IMEM_W_En   = w_en_q;
  assign IMEM_W_Addr = w_addr_q;
  assign IMEM_W_Data = w_data_q;
  assign Core_Hold   = hold_q;
  assign Load_Done   = done_q;
  assign Load_Err    = err_q;

  // Receiver: a start edge is re-checked at mid-bit so short glitches are dropped.
  always_comb begin
    rx_state_d  = rx_state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          cnt_d      = CNT_W'(HALF - 1);
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          if (!rx_s2_q) begin
            rx_state_d = RX_DATA;
            cnt_d      = CNT_W'(DIV - 1);
            bit_idx_d  = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          cnt_d   = CNT_W'(DIV - 1);
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        if (cnt_q == '0) begin
          byte_vld_d  = rx_s2_q;
          frame_err_d = !rx_s2_q;
          rx_state_d  = RX_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  assign count_w = {shift_q, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    chk_d      = chk_q;
    w_en_d     = 1'b0;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (byte_vld_q && shift_q == 8'hA5) begin
          state_d    = S_LEN_LO;
          done_d     = 1'b0;
          err_d      = 1'b0;
          hold_d     = 1'b1;
          idx_d      = '0;
          chk_d      = 8'h00;
          byte_cnt_d = 2'd0;
        end
      end
      default: begin
        if (frame_err_q) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (byte_vld_q) begin
          case (state_q)
            S_LEN_LO: begin
              len_d   = {8'h00, shift_q};
              state_d = S_LEN_HI;
            end
            S_LEN_HI: begin
              len_d = count_w;
              if (count_w == 16'd0 || 32'(count_w) > (32'd1 << ADDR_W)) begin
                state_d = S_ERR;
                err_d   = 1'b1;
              end else begin
                state_d = S_DATA;
              end
            end
            S_DATA: begin
              chk_d = chk_q ^ shift_q;
              if (byte_cnt_q == 2'd3) begin
                w_en_d     = 1'b1;
                w_addr_d   = idx_q[ADDR_W-1:0];
                w_data_d   = {shift_q, word_q};
                idx_d      = idx_q + 1'b1;
                byte_cnt_d = 2'd0;
                if (32'(idx_q) + 32'd1 == 32'(len_q)) state_d = S_CHK;
              end else begin
                word_d     = {shift_q, word_q[23:8]};
                byte_cnt_d = byte_cnt_q + 1'b1;
              end
            end
            default: begin
              if (shift_q == chk_q) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                hold_d  = 1'b0;
              end else begin
                state_d = S_ERR;
                err_d   = 1'b1;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_state_q  <= RX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      state_q     <= S_IDLE;
      len_q       <= 16'd0;
      idx_q       <= '0;
      byte_cnt_q  <= 2'd0;
      word_q      <= 24'd0;
      chk_q       <= 8'h00;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= 32'd0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rx_s1_q     <= UART_RX;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
      rx_state_q  <= rx_state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      state_q     <= state_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      chk_q       <= chk_d;
      w_en_q      <= w_en_d;
      w_addr_q    <= w_addr_d;
      w_data_q    <= w_data_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: UART byte driver, write scoreboard with an
// expected queue drained by an independent monitor, flag checks per scenario.
module tb_imem_loader;

  localparam int CLK_FREQ_HZ = 1000000;
  localparam int BAUD        = 62500;
  localparam int ADDR_W      = 10;
  localparam int DIV         = CLK_FREQ_HZ / BAUD;
  localparam int EW          = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              uart_rx = 1'b1;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_data;
  logic              core_hold, load_done, load_err;

  logic [EW-1:0] exp_q[$];
  logic [7:0]    tx_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          prev_en = 1'b0;

  imem_loader #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .CLK(clk), .RST(rst_n), .UART_RX(uart_rx),
    .IMEM_W_En(w_en), .IMEM_W_Addr(w_addr), .IMEM_W_Data(w_data),
    .Core_Hold(core_hold), .Load_Done(load_done), .Load_Err(load_err)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every write strobe is matched against the expected queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (w_en) begin
        check("strobe_single_cycle", {63'd0, prev_en}, 64'd0);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", w_addr, w_data);
        end else begin
          check("write", {22'd0, w_addr, w_data}, {22'd0, exp_q.pop_front()});
        end
      end
      prev_en = w_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  // driver tasks
  task automatic expect_write(input int a, input logic [31:0] d);
    exp_q.push_back({ADDR_W'(a), d});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    uart_rx = stop;
    repeat (DIV) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
  endtask

  task automatic send_all();
    while (tx_q.size() != 0) send_byte(tx_q.pop_front(), 1'b1);
  endtask

  task automatic check_flags(input string name, input logic done, input logic err, input logic hold);
    check({name, "_done"}, {63'd0, load_done}, {63'd0, done});
    check({name, "_err"},  {63'd0, load_err},  {63'd0, err});
    check({name, "_hold"}, {63'd0, core_hold}, {63'd0, hold});
  endtask

  task automatic check_drained(input string name);
    check({name, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_w_en"},   {63'd0, w_en}, 64'd0);
    check({name, "_w_addr"}, 64'(w_addr), 64'd0);
    check({name, "_w_data"}, 64'(w_data), 64'd0);
    check_flags(name, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (4 * DIV) @(negedge clk);
    check_reset_outputs("post_reset_idle");

    // good two-word load
    expect_write(0, 32'h00000093);
    expect_write(1, 32'h00100113);
    send_byte(8'hA5, 1'b1);
    check_flags("good_hdr", 1'b0, 1'b0, 1'b1);
    tx_q = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    send_all();
    check_flags("good_pre_chk", 1'b0, 1'b0, 1'b1);
    check_drained("good_words");
    send_byte(8'h91, 1'b1);
    check_flags("good_end", 1'b1, 1'b0, 1'b0);
    check("good_addr_hold", 64'(w_addr), 64'd1);
    check("good_data_hold", 64'(w_data), 64'h00100113);

    // bad checksum: words still written
    expect_write(0, 32'h00000093);
    expect_write(1, 32'h00100113);
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h90};
    send_all();
    check_flags("bad_chk", 1'b0, 1'b1, 1'b1);
    check_drained("bad_chk");

    // zero length, then oversize length
    send_byte(8'hA5, 1'b1);
    check_flags("len0_hdr", 1'b0, 1'b0, 1'b1);
    tx_q = '{8'h00, 8'h00};
    send_all();
    check_flags("len0", 1'b0, 1'b1, 1'b1);
    send_byte(8'hA5, 1'b1);
    check_flags("len1025_hdr", 1'b0, 1'b0, 1'b1);
    tx_q = '{8'h01, 8'h04};
    send_all();
    check_flags("len1025", 1'b0, 1'b1, 1'b1);

    // length 1024 is accepted; a framing error then aborts it
    tx_q = '{8'hA5, 8'h00, 8'h04};
    send_all();
    check_flags("len1024", 1'b0, 1'b0, 1'b1);
    send_byte(8'h11, 1'b0);
    check_flags("len1024_frame_err", 1'b0, 1'b1, 1'b1);

    // framing error on second data byte, then a good stream
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h93};
    send_all();
    send_byte(8'h00, 1'b0);
    check_flags("frame_err", 1'b0, 1'b1, 1'b1);
    expect_write(0, 32'hDEADBEEF);
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_all();
    check_flags("recover", 1'b1, 1'b0, 1'b0);
    check_drained("recover");

    // short glitch and a 0x00 byte in idle are ignored
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (2 * DIV) @(negedge clk);
    check_flags("glitch", 1'b1, 1'b0, 1'b0);
    send_byte(8'h00, 1'b1);
    check_flags("idle_zero", 1'b1, 1'b0, 1'b0);
    expect_write(0, 32'h12345678);
    send_byte(8'hA5, 1'b1);
    check_flags("glitch_hdr", 1'b0, 1'b0, 1'b1);
    tx_q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_all();
    check_flags("glitch_load", 1'b1, 1'b0, 1'b0);
    check_drained("glitch_load");

    // reset mid-load after five data bytes
    expect_write(0, 32'h00000093);
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13};
    send_all();
    check_flags("pre_reset", 1'b0, 1'b0, 1'b1);
    check_drained("pre_reset");
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    check_reset_outputs("after_reset");
    expect_write(0, 32'hDEADBEEF);
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    send_all();
    check_flags("fresh_load", 1'b1, 1'b0, 1'b0);
    check("fresh_addr", 64'(w_addr), 64'd0);
    check("fresh_data", 64'(w_data), 64'hDEADBEEF);
    check_drained("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 40000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, UART bit rate; bit period DIV = CLK_FREQ_HZ/BAUD (integer, truncated).
REQ-003 Parameter ADDR_W, default 10, instruction-memory word-address width (1024 words).
REQ-004 CLK  input  1  system clock; all state on rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 UART_RX  input  1  serial line, idle high, 8N1, LSB first, asynchronous to CLK.
REQ-007 IMEM_W_En  output  1  one-cycle instruction-memory write strobe.
REQ-008 IMEM_W_Addr  output  ADDR_W  word address of the current write.
REQ-009 IMEM_W_Data  output  32  word to write.
REQ-010 Core_Hold  output  1  1 = core held in reset while a load is in progress or has failed.
REQ-011 Load_Done  output  1  sticky, 1 = last load completed with correct checksum.
REQ-012 Load_Err  output  1  sticky, 1 = last load aborted (framing, length or checksum error).

Function
REQ-013 UART_RX SHALL pass through a 2-flop synchroniser before any use.
REQ-014 Receiver SHALL detect a start bit on a synchronised 1->0 transition while idle, resample at DIV/2; if high, discard and return to idle.
REQ-015 Receiver SHALL sample 8 data bits every DIV cycles from the start-bit midpoint, LSB first, then the stop bit.
REQ-016 Stop bit = 1 SHALL produce a one-cycle internal byte-valid pulse the cycle after the stop sample; stop bit = 0 SHALL produce a one-cycle framing-error pulse instead.
REQ-017 Loader FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
REQ-018 IDLE/DONE/ERR: byte 0xA5 -> LEN_LO, clear Load_Done and Load_Err, set Core_Hold, clear word index and checksum; any other byte or framing error ignored.
REQ-019 LEN_LO -> LEN_HI on byte (count[7:0]); LEN_HI -> DATA on byte (count[15:8]).
REQ-020 On leaving LEN_HI, count = 0 or count > 2^ADDR_W SHALL go to ERR instead of DATA.
REQ-021 DATA: bytes assemble little-endian into {b3,b2,b1,b0}; checksum ^= each byte.
REQ-022 On the 4th byte of a word, IMEM_W_En SHALL pulse high for exactly one cycle, the cycle after that byte's valid pulse, with IMEM_W_Addr = word index (first word 0) and IMEM_W_Data = assembled word; index then increments.
REQ-023 After word count-1 is written, FSM SHALL go to CHK; next byte equal to checksum -> DONE, else -> ERR.
REQ-024 Entering DONE: Load_Done = 1 and Core_Hold = 0 in the same cycle.
REQ-025 Entering ERR: Load_Err = 1, Core_Hold stays 1; words already written are not reverted.
REQ-026 Framing error in LEN_LO, LEN_HI, DATA or CHK SHALL go to ERR; partial word discarded, no write.
REQ-027 IMEM_W_En SHALL be 0 in every cycle other than REQ-022 strobes; IMEM_W_Addr/Data hold last values between strobes.
REQ-028 Byte 0xA5 inside LEN/DATA/CHK is payload, not a resync.
REQ-029 Word index width ADDR_W+1 internally; no wrap occurs because REQ-020 bounds count.

Reset
REQ-030 RST = 0 SHALL immediately force: FSM IDLE, receiver idle, synchroniser flops to 1, IMEM_W_En 0, IMEM_W_Addr 0, IMEM_W_Data 0, Core_Hold 0, Load_Done 0, Load_Err 0, checksum and index 0.
REQ-031 Reset asserted mid-load SHALL abort with no further write; partial byte/word discarded.
REQ-032 Outputs leave reset values only on clock edges after RST returns to 1.

Verification
REQ-033 Bytes A5 02 00 93 00 00 00 13 01 10 00 91 -> writes (0,0x00000093),(1,0x00100113), each a single-cycle strobe; Load_Done 1, Core_Hold 1->0 on checksum byte, Load_Err 0.
REQ-034 Same stream, checksum 0x90 -> both writes occur, Load_Err 1, Load_Done 0, Core_Hold stays 1.
REQ-035 A5 00 00 -> ERR, no writes; A5 01 04 (count 1025, ADDR_W 10) -> ERR, no writes.
REQ-036 Stop bit forced 0 on second data byte -> ERR, no write strobe; subsequent valid stream A5 01 00 EF BE AD DE 22 -> write (0,0xDEADBEEF), Load_Done 1.
REQ-037 Glitch low on UART_RX shorter than DIV/2 in IDLE -> no byte, no state change; byte 0x00 in IDLE -> ignored.
REQ-038 RST pulsed low after 5 data bytes -> all outputs at reset values, no further write, fresh A5 stream loads correctly.
